// File: rtl/reed_solomon_decoder_pkg.sv
// Shared types and constants for the Reed-Solomon decoder FIFO controller.
package reed_solomon_decoder_pkg;

  localparam int LINE_BYTES = 64;
  localparam int LINE_BITS  = LINE_BYTES * 8;

  typedef logic [LINE_BITS-1:0] rs_line_t;

  typedef enum logic {
    IDLE  = 1'b0,
    IN_CW = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/reed_solomon_decoder_rr_arb.sv
// Two-way round-robin arbiter: the pointer names the requester that is
// preferred this cycle and flips to the loser after every grant.
module reed_solomon_decoder_rr_arb (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       space_ok,
  output logic [1:0] grant
);

  logic prio;

  // Pick the preferred requester if it is asking, otherwise the other one;
  // nothing is granted unless the FIFO can take a whole line.
  always_comb begin
    grant = 2'b00;
    if (space_ok) begin
      if (valid[prio]) begin
        grant[prio] = 1'b1;
      end else if (valid[~prio]) begin
        grant[~prio] = 1'b1;
      end
    end
  end

  // After a grant the loser becomes preferred; grant[0] set means requester 1 is next.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio <= 1'b0;
    end else if (|grant) begin
      prio <= grant[0];
    end
  end

endmodule

// File: rtl/reed_solomon_decoder_fifo_ctrl.sv
// Front/back controller for the decoder byte FIFO: admits 64-byte lines from
// two requesters only when they fit, and drains bytes as framed codewords.
module reed_solomon_decoder_fifo_ctrl
  import reed_solomon_decoder_pkg::*;
#(
  parameter  int FIFO_DEPTH   = 512,
  parameter  int CODEWORD_LEN = 255,
  localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         req_valid,
  input  rs_line_t [1:0]     req_data,
  output logic [1:0]         req_ready,
  output rs_line_t           fifo_enq_data,
  output logic               fifo_enq_en,
  input  logic [CNT_W-1:0]   fifo_counter,
  input  logic               fifo_not_empty,
  input  logic [7:0]         fifo_deq_data,
  output logic               fifo_deq_en,
  output logic               out_valid,
  output logic [7:0]         out_data,
  output logic               out_sop,
  output logic               out_eop,
  input  logic               out_ready,
  input  logic               enable,
  output logic               overflow_err,
  output fsm_state_t         cw_state
);

  localparam logic [CNT_W:0] SPACE_LIMIT = (CNT_W + 1)'(FIFO_DEPTH - LINE_BYTES);
  localparam logic [CNT_W:0] DEPTH_EXT   = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [15:0]    LAST_BYTE   = 16'(CODEWORD_LEN - 1);

  logic        space_ok;
  logic [1:0]  grant;
  logic        accept;
  logic        at_sop;
  logic        at_eop;
  logic [15:0] bcnt;

  // The space check ignores a same-cycle pop, so it can only under-admit.
  assign space_ok = ({1'b0, fifo_counter} <= SPACE_LIMIT);

  // Reset is folded into the qualifier so no grant can escape while held in reset.
  reed_solomon_decoder_rr_arb u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .valid    (req_valid),
    .space_ok (space_ok & reset_n),
    .grant    (grant)
  );

  assign req_ready     = grant;
  assign fifo_enq_en   = |grant;
  assign fifo_enq_data = grant[1] ? req_data[1] : req_data[0];

  // The read side is purely combinational so a pop follows out_ready at once.
  assign out_valid   = reset_n & enable & fifo_not_empty;
  assign out_data    = fifo_deq_data;
  assign accept      = out_valid & out_ready;
  assign fifo_deq_en = accept;

  assign at_sop  = (bcnt == 16'd0);
  assign at_eop  = (bcnt == LAST_BYTE);
  assign out_sop = reset_n & at_sop;
  assign out_eop = reset_n & at_eop;

  // Framing: count accepted bytes and track whether a codeword is open.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcnt     <= 16'd0;
      cw_state <= IDLE;
    end else if (accept) begin
      bcnt <= at_eop ? 16'd0 : bcnt + 16'd1;
      case (cw_state)
        IDLE:    if (at_sop && !at_eop) cw_state <= IN_CW;
        IN_CW:   if (at_eop) cw_state <= IDLE;
        default: cw_state <= IDLE;
      endcase
    end
  end

  // Sticky occupancy error; only a reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_err <= 1'b0;
    end else if ({1'b0, fifo_counter} > DEPTH_EXT) begin
      overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reed_solomon_decoder_fifo_ctrl.sv
// Self-checking bench: a byte-queue model of the FIFO plus the arbitration
// and framing rules, driven by directed scenarios and random traffic.
module tb_reed_solomon_decoder_fifo_ctrl;
  import reed_solomon_decoder_pkg::*;

  localparam int FIFO_DEPTH = 512;
  localparam int CW_LEN     = 255;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic              clk;
  logic              reset_n;
  logic [1:0]        req_valid;
  logic [1:0][511:0] req_data;
  logic [1:0]        req_ready;
  logic [511:0]      fifo_enq_data;
  logic              fifo_enq_en;
  logic [CNT_W-1:0]  fifo_counter;
  logic              fifo_not_empty;
  logic [7:0]        fifo_deq_data;
  logic              fifo_deq_en;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_sop;
  logic              out_eop;
  logic              out_ready;
  logic              enable;
  logic              overflow_err;
  fsm_state_t        cw_state;

  reed_solomon_decoder_fifo_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .CODEWORD_LEN(CW_LEN)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .fifo_enq_data  (fifo_enq_data),
    .fifo_enq_en    (fifo_enq_en),
    .fifo_counter   (fifo_counter),
    .fifo_not_empty (fifo_not_empty),
    .fifo_deq_data  (fifo_deq_data),
    .fifo_deq_en    (fifo_deq_en),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .out_ready      (out_ready),
    .enable         (enable),
    .overflow_err   (overflow_err),
    .cw_state       (cw_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] mq[$];
  int         mprio;
  int         mbcnt;
  bit         movf;

  // Bench-side stimulus variables
  logic [1:0]   rv;
  logic [511:0] rdata [2];
  bit           en;
  bit           ordy;
  bit           use_ovr;
  int           ovr_val;

  // Observations from the most recent cycle
  logic [1:0] obs_ready;
  bit         obs_sop;
  bit         obs_eop;
  bit         obs_deq;
  bit         obs_ovf;

  task automatic checkOutput(input string tag, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic randLine(output logic [511:0] v);
    for (int k = 0; k < 16; k++) v[32*k +: 32] = $urandom;
  endtask

  task automatic preload(input int n);
    for (int k = 0; k < n; k++) mq.push_back(8'($urandom));
  endtask

  task automatic driveInputs();
    req_valid      = rv;
    req_data[0]    = rdata[0];
    req_data[1]    = rdata[1];
    enable         = en;
    out_ready      = ordy;
    fifo_counter   = use_ovr ? CNT_W'(ovr_val) : CNT_W'(mq.size());
    fifo_not_empty = (mq.size() != 0);
    fifo_deq_data  = (mq.size() != 0) ? mq[0] : 8'h00;
  endtask

  // One clock: drive at negedge, check 1ns later, update model at posedge.
  task automatic applyStimulus();
    int cnt;
    int w;
    bit sok;
    bit exp_valid;
    bit exp_deq;
    bit exp_eop;
    driveInputs();
    cnt = use_ovr ? ovr_val : mq.size();
    #1;
    sok = (cnt <= FIFO_DEPTH - LINE_BYTES);
    w = -1;
    if (sok) begin
      if (rv[mprio]) w = mprio;
      else if (rv[1-mprio]) w = 1 - mprio;
    end
    exp_valid = en && (mq.size() != 0);
    exp_deq   = exp_valid && ordy;
    exp_eop   = (mbcnt == CW_LEN - 1);
    checkOutput("req_ready", 512'(req_ready), (w < 0) ? 512'(0) : 512'(1 << w));
    checkOutput("fifo_enq_en", 512'(fifo_enq_en), 512'(w >= 0));
    if (w >= 0) checkOutput("fifo_enq_data", fifo_enq_data, rdata[w]);
    checkOutput("out_valid", 512'(out_valid), 512'(exp_valid));
    checkOutput("fifo_deq_en", 512'(fifo_deq_en), 512'(exp_deq));
    checkOutput("out_sop", 512'(out_sop), 512'(mbcnt == 0));
    checkOutput("out_eop", 512'(out_eop), 512'(exp_eop));
    if (exp_valid) checkOutput("out_data", 512'(out_data), 512'(mq[0]));
    checkOutput("overflow_err", 512'(overflow_err), 512'(movf));
    checkOutput("cw_state", 512'(cw_state), 512'((mbcnt != 0) ? IN_CW : IDLE));
    obs_ready = req_ready;
    obs_sop   = out_sop;
    obs_eop   = out_eop;
    obs_deq   = fifo_deq_en;
    obs_ovf   = overflow_err;
    @(posedge clk);
    if (exp_deq) begin
      void'(mq.pop_front());
      mbcnt = exp_eop ? 0 : mbcnt + 1;
    end
    if (w >= 0) begin
      for (int i = 0; i < LINE_BYTES; i++) mq.push_back(rdata[w][8*i +: 8]);
      rv[w] = 1'b0;
      mprio = 1 - w;
    end
    if (cnt > FIFO_DEPTH) movf = 1'b1;
    @(negedge clk);
  endtask

  task automatic resetCheck(input string tag);
    checkOutput({tag, "_req_ready"}, 512'(req_ready), 512'(0));
    checkOutput({tag, "_enq_en"}, 512'(fifo_enq_en), 512'(0));
    checkOutput({tag, "_deq_en"}, 512'(fifo_deq_en), 512'(0));
    checkOutput({tag, "_out_valid"}, 512'(out_valid), 512'(0));
    checkOutput({tag, "_sop"}, 512'(out_sop), 512'(0));
    checkOutput({tag, "_eop"}, 512'(out_eop), 512'(0));
    checkOutput({tag, "_ovf"}, 512'(overflow_err), 512'(0));
    checkOutput({tag, "_state"}, 512'(cw_state), 512'(IDLE));
  endtask

  // Asynchronous reset asserted between edges while inputs stay live.
  task automatic doReset(input string tag);
    #3;
    reset_n = 1'b0;
    #1;
    resetCheck(tag);
    mprio = 0;
    mbcnt = 0;
    movf  = 1'b0;
    rv    = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drain(input int n);
    en = 1'b1;
    ordy = 1'b1;
    rv = 2'b00;
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  initial begin
    int pops;
    mprio = 0; mbcnt = 0; movf = 1'b0;
    use_ovr = 1'b0; ovr_val = 0;
    randLine(rdata[0]);
    randLine(rdata[1]);

    // Reset with everything asking for service
    reset_n = 1'b0;
    rv = 2'b11; en = 1'b1; ordy = 1'b1;
    preload(3);
    driveInputs();
    #1;
    resetCheck("por");
    mq.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Both requesters valid every cycle: strict alternation starting at 0
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rv = 2'b11;
      randLine(rdata[0]);
      randLine(rdata[1]);
      applyStimulus();
      checkOutput("alternation", 512'(obs_ready), (i % 2 == 0) ? 512'(1) : 512'(2));
    end
    drain(6 * LINE_BYTES);

    // Two full codewords back to back
    doReset("rst_a");
    preload(510);
    en = 1'b1; ordy = 1'b1; rv = 2'b00;
    pops = 0;
    for (int i = 0; i < 510; i++) begin
      applyStimulus();
      if (obs_deq) pops++;
      checkOutput("drain_sop", 512'(obs_sop), 512'(i == 0 || i == 255));
      checkOutput("drain_eop", 512'(obs_eop), 512'(i == 254 || i == 509));
    end
    checkOutput("drain_pops", 512'(pops), 512'(510));

    // Pause the drain mid-codeword and resume without a new sop
    preload(150);
    drain(100);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      checkOutput("pause_no_pop", 512'(obs_deq), 512'(0));
    end
    en = 1'b1;
    applyStimulus();
    checkOutput("resume_pop", 512'(obs_deq), 512'(1));
    checkOutput("resume_sop", 512'(obs_sop), 512'(0));
    drain(49);

    // Reset in the middle of a codeword discards the partial frame
    preload(100);
    drain(50);
    doReset("rst_mid");
    en = 1'b1; ordy = 1'b1;
    applyStimulus();
    checkOutput("post_reset_pop", 512'(obs_deq), 512'(1));
    checkOutput("post_reset_sop", 512'(obs_sop), 512'(1));
    drain(49);

    // Space boundary: 448 admits, 449 stalls the lone requester
    en = 1'b0; use_ovr = 1'b1; ovr_val = FIFO_DEPTH - LINE_BYTES;
    rv = 2'b10;
    randLine(rdata[1]);
    applyStimulus();
    checkOutput("boundary_448", 512'(obs_ready), 512'(2));
    rv = 2'b10;
    randLine(rdata[1]);
    ovr_val = FIFO_DEPTH - LINE_BYTES + 1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput("boundary_449", 512'(obs_ready), 512'(0));
    end
    ovr_val = FIFO_DEPTH - LINE_BYTES;
    applyStimulus();
    checkOutput("boundary_resume", 512'(obs_ready), 512'(2));

    // Overflow is sticky until reset
    ovr_val = FIFO_DEPTH + 1;
    applyStimulus();
    ovr_val = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("ovf_sticky", 512'(obs_ovf), 512'(1));
    end
    use_ovr = 1'b0;
    doReset("rst_ovf");
    drain(2 * LINE_BYTES);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!rv[r] && ($urandom % 10) < 4) begin
          rv[r] = 1'b1;
          randLine(rdata[r]);
        end
      end
      en   = (($urandom % 10) < 9);
      ordy = (($urandom % 4) != 0);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
